// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch / prefetch path.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched {pc, instr} words; flush empties it in one cycle.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int CW = clog2(DEPTH + 1),
  localparam int PW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

endmodule

// File: rtl/fetch_prefetch_unit.sv
// IF stage with a prefetch queue: issues sequential fetches under a credit limit
// and squashes responses that belong to a stream abandoned by a redirect.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            ValidF,
  output logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int OW = clog2(MAX_OUT + 1);

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   rsp_pc;
  logic [OW-1:0]     outstanding;
  logic [OW-1:0]     drop_cnt;
  logic [CW-1:0]     buf_count;
  logic              buf_full;
  logic              buf_empty;
  logic [2*XLEN-1:0] buf_head;
  logic [XLEN-1:0]   target_aligned;
  logic [31:0]       occupancy;
  logic              req_fire;
  logic              rsp_push;
  logic              deq;

  // Request handshake: a transfer happens on a rising edge where valid && ready.
  // Valid may fall without ready (credit exhausted or redirect); while it stays
  // high the address does not change. Responses carry no ready and come in order.
  assign target_aligned = {PCTargetE[XLEN-1:2], 2'b00};
  // Live words = buffered + in flight and not doomed to be dropped.
  assign occupancy = 32'(buf_count) + 32'(outstanding) - 32'(drop_cnt);
  assign imem_req_valid = !rst && !PCSrcE && (32'(outstanding) < 32'(MAX_OUT))
                          && (occupancy < 32'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_push       = imem_rsp_valid && (drop_cnt == '0) && !PCSrcE;
  assign deq            = !buf_empty && !stall && !PCSrcE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (PCSrcE) begin
        fetch_pc <= target_aligned;
        rsp_pc   <= target_aligned;
        drop_cnt <= outstanding - OW'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_push) rsp_pc   <= rsp_pc + XLEN'(4);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
      end
      outstanding <= outstanding + OW'(req_fire) - OW'(imem_rsp_valid);
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .pop       (deq),
    .flush     (PCSrcE),
    .push_data ({rsp_pc, imem_rsp_data}),
    .head_data (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign ValidF   = !buf_empty;
  assign PCF      = buf_empty ? '0 : buf_head[2*XLEN-1:XLEN];
  assign InstrF   = buf_empty ? '0 : buf_head[XLEN-1:0];
  assign PCPlus4F = PCF + XLEN'(4);

  no_push_when_full : assert property (@(posedge clk) disable iff (rst) !(rsp_push && buf_full));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit against a tagged in-flight/queue model.
module tb_fetch_prefetch_unit;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam int W       = 2 * XLEN;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } req_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            ValidF;
  logic [XLEN-1:0] InstrF;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] PCPlus4F;

  logic [W-1:0] exp_q[$];
  req_t         pending[$];
  logic [31:0]  exp_req_addr;
  int           cyc;
  int           lat_min;
  int           lat_max;
  int           checks;
  int           errors;

  // ---------------- clock / reset
  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .MAX_OUT  (MAX_OUT),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ValidF         (ValidF),
    .InstrF         (InstrF),
    .PCF            (PCF),
    .PCPlus4F       (PCPlus4F)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    stall          = 1'b0;
    PCSrcE         = 1'b0;
    PCTargetE      = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    #1;
    check("rst_validf",    64'(ValidF),         64'd0);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_pcf",       64'(PCF),            64'd0);
    check("rst_instrf",    64'(InstrF),         64'd0);
    check("rst_pcplus4f",  64'(PCPlus4F),       64'd4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    pending.delete();
    exp_req_addr = 32'h0;
  endtask

  // ---------------- driver: one cycle of stimulus, output checks and model update
  task automatic step(input bit st, input bit rd, input logic [31:0] tgt, input bit rdy);
    bit          rsp;
    bit          exp_rv;
    int          live;
    req_t        e;
    logic [W-1:0] h;
    logic [31:0] hp;
    stall          = st;
    PCSrcE         = rd;
    PCTargetE      = tgt;
    imem_req_ready = rdy;
    rsp = (pending.size() != 0) && (pending[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_fn(pending[0].addr) : $urandom;
    #1;
    live = 0;
    foreach (pending[i]) if (!pending[i].stale) live++;
    exp_rv = !rd && (pending.size() < MAX_OUT) && ((exp_q.size() + live) < DEPTH);

    check("validf", 64'(ValidF), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      h  = exp_q[0];
      hp = h[63:32] + 32'd4;
      check("pcf",      64'(PCF),      64'(h[63:32]));
      check("instrf",   64'(InstrF),   64'(h[31:0]));
      check("pcplus4f", 64'(PCPlus4F), 64'(hp));
    end else begin
      check("pcf_empty",      64'(PCF),      64'd0);
      check("instrf_empty",   64'(InstrF),   64'd0);
      check("pcplus4f_empty", 64'(PCPlus4F), 64'd4);
    end
    check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (exp_rv) check("req_addr", 64'(imem_req_addr), 64'(exp_req_addr));

    if ((exp_q.size() != 0) && !st && !rd) void'(exp_q.pop_front());
    if (rsp) begin
      e = pending.pop_front();
      if (!e.stale && !rd) exp_q.push_back({e.addr, mem_fn(e.addr)});
    end
    if (rd) begin
      exp_q.delete();
      foreach (pending[i]) pending[i].stale = 1'b1;
      exp_req_addr = {tgt[31:2], 2'b00};
    end else if (exp_rv && rdy) begin
      e.addr  = exp_req_addr;
      e.stale = 1'b0;
      e.due   = cyc + int'($urandom_range(lat_max, lat_min));
      pending.push_back(e);
      exp_req_addr = exp_req_addr + 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_plain(input int n);
    repeat (n) step(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  // ---------------- stimulus
  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    lat_min = 1;
    lat_max = 1;
    do_reset();

    // Sequential stream from reset, single-cycle memory.
    run_plain(12);

    // Long stall: queue fills to DEPTH, then requests stop.
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1);
    check("stall_full_req_valid", 64'(imem_req_valid), 64'd0);
    run_plain(4);

    // Redirect with two slow requests in flight.
    lat_min = 3;
    lat_max = 3;
    run_plain(3);
    step(1'b0, 1'b1, 32'h100, 1'b1);
    run_plain(10);

    // Back-to-back redirects with responses in flight.
    lat_min = 1;
    lat_max = 2;
    run_plain(3);
    step(1'b0, 1'b1, 32'h180, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b1);
    run_plain(10);

    // Memory refuses requests for a while.
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0);
    run_plain(8);

    // Address wrap and unaligned target.
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    run_plain(8);
    step(1'b0, 1'b1, 32'h0000_0102, 1'b1);
    run_plain(6);

    // Random traffic.
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 5, tgt,
           $urandom_range(99, 0) < 70);
    end

    // Asynchronous reset in the middle of traffic.
    @(posedge clk);
    #2;
    do_reset();
    run_plain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
